// File: rtl/framebuffer_stream_axi_writer_pkg.sv
// rtl/framebuffer_stream_axi_writer_pkg.sv - shared types and AXI constants for the stream-to-AXI writer
// Contents: FSM state enum, AXI burst/response encodings, 4 KiB boundary size,
//           f_awsize() returning log2(bytes per beat) for a given data width.
package framebuffer_stream_axi_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } fsw_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned BOUNDARY_4K = 4096;

  // AWSIZE encoding: log2 of the number of bytes in one data beat.
  function automatic logic [2:0] f_awsize(input int unsigned data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == (data_width / 8)) size = i[2:0];
    end
    return size;
  endfunction

endpackage

// File: rtl/framebuffer_stream_axi_writer_if.sv
// rtl/framebuffer_stream_axi_writer_if.sv - command, pixel stream and AXI4 write bundle
// Groups: command (s_avalid/s_aaddr/s_abytes/s_aready), AXIS pixel stream (s_axis_*),
//         AXI4 AW/W/B channels (m_axi_*).
// Modports: master = the writer block, slave = framebuffer source plus memory side.
interface framebuffer_stream_axi_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic                    s_avalid;
  logic [ADDR_WIDTH-1:0]   s_aaddr;
  logic [ADDR_WIDTH-1:0]   s_abytes;
  logic                    s_aready;

  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tstrb;

  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;

  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  logic [ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    input  s_avalid, s_aaddr, s_abytes,
    output s_aready,
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    output s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_avalid, s_aaddr, s_abytes,
    input  s_aready,
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/stream_axi_burst_calc.sv
// rtl/stream_axi_burst_calc.sv - combinational beat count for the next AXI burst
// Ports: i_addr (current byte address), i_remaining (beats left), o_burst_beats.
// Macro: STREAM_AXI_WRITER_4K_SPLIT_EN additionally stops bursts at 4 KiB boundaries.
module stream_axi_burst_calc
  import framebuffer_stream_axi_writer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] i_remaining,
  output logic [ADDR_WIDTH-1:0] o_burst_beats
);

  localparam int BYTE_SHIFT = int'(f_awsize(DATA_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(MAX_BURST_BEATS);

  logic w_unused_addr;
  assign w_unused_addr = ^i_addr;

`ifdef STREAM_AXI_WRITER_4K_SPLIT_EN
  // Beats that fit between the (beat-aligned) address and the next 4 KiB page.
  logic [12:0] w_beats_to_4k;
  assign w_beats_to_4k = (13'(BOUNDARY_4K) - {1'b0, i_addr[11:0]}) >> BYTE_SHIFT;

  always_comb begin
    o_burst_beats = (i_remaining > MAX_BEATS) ? MAX_BEATS : i_remaining;
    if (ADDR_WIDTH'(w_beats_to_4k) < o_burst_beats) o_burst_beats = ADDR_WIDTH'(w_beats_to_4k);
  end
`else
  always_comb begin
    o_burst_beats = (i_remaining > MAX_BEATS) ? MAX_BEATS : i_remaining;
  end
`endif

endmodule

// File: rtl/framebuffer_stream_axi_writer.sv
// rtl/framebuffer_stream_axi_writer.sv - writes one framebuffer AXIS transfer to memory as AXI4 INCR bursts
// Ports: clk, reset (async, active-high), bus (framebuffer_stream_axi_writer_if.master:
//        command, pixel stream, AXI4 AW/W/B), o_busy (command accept to final B), o_error (sticky).
// Macro: STREAM_AXI_WRITER_4K_SPLIT_EN (see stream_axi_burst_calc) enables 4 KiB burst splitting.
module framebuffer_stream_axi_writer
  import framebuffer_stream_axi_writer_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int ID_WIDTH        = 1
) (
  input  logic clk,
  input  logic reset,
  framebuffer_stream_axi_writer_if.master bus,
  output logic o_busy,
  output logic o_error
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = int'(f_awsize(DATA_WIDTH));

  fsw_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [ADDR_WIDTH-1:0] r_beat;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_busy;
  logic                  r_error;

  logic [ADDR_WIDTH-1:0] w_burst_beats;
  logic [ADDR_WIDTH:0]   w_bytes_round;
  logic [ADDR_WIDTH-1:0] w_cmd_beats;
  logic                  w_last_beat;
  logic                  w_final_burst;
  logic                  w_w_hs;
  logic                  w_unused_bid;

  // Burst size is derived from registered address/remaining, so it stays
  // stable across the whole AW -> W -> B sequence of one burst.
  stream_axi_burst_calc #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_burst_calc (
    .i_addr        (r_addr),
    .i_remaining   (r_remaining),
    .o_burst_beats (w_burst_beats)
  );

  // Round partial trailing words up to a full beat.
  assign w_bytes_round = {1'b0, bus.s_abytes} + (ADDR_WIDTH+1)'(BYTES - 1);
  assign w_cmd_beats   = ADDR_WIDTH'(w_bytes_round >> BYTE_SHIFT);

  assign w_last_beat   = (r_beat == w_burst_beats - 1'b1);
  assign w_final_burst = (w_burst_beats == r_remaining);
  assign w_w_hs        = (r_state == ST_W) && bus.s_axis_tvalid && bus.m_axi_wready;
  assign w_unused_bid  = ^bus.m_axi_bid;

  assign bus.s_aready      = (r_state == ST_IDLE);
  // Zero-latency pass-through of the pixel stream onto the W channel.
  assign bus.s_axis_tready = (r_state == ST_W) && bus.m_axi_wready;
  assign bus.m_axi_wvalid  = (r_state == ST_W) && bus.s_axis_tvalid;
  assign bus.m_axi_wdata   = bus.s_axis_tdata;
  assign bus.m_axi_wstrb   = bus.s_axis_tstrb;
  assign bus.m_axi_wlast   = (r_state == ST_W) && w_last_beat;

  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = w_burst_beats[7:0] - 8'd1;
  assign bus.m_axi_awsize  = f_awsize(DATA_WIDTH);
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_bready  = r_bready;

  assign o_busy  = r_busy;
  assign o_error = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beat      <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.s_avalid) begin
            r_error     <= 1'b0;
            r_addr      <= bus.s_aaddr;
            r_remaining <= w_cmd_beats;
            r_beat      <= '0;
            // Zero-length commands are consumed without any bus activity.
            if (w_cmd_beats != '0) begin
              r_state   <= ST_AW;
              r_awvalid <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (bus.m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_beat    <= '0;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (w_w_hs) begin
            // tlast is only checked; the beat count decides where the transfer ends.
            if (bus.s_axis_tlast != (w_final_burst && w_last_beat)) r_error <= 1'b1;
            if (w_last_beat) begin
              r_bready <= 1'b1;
              r_state  <= ST_B;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_B: begin
          if (bus.m_axi_bvalid) begin
            r_bready    <= 1'b0;
            if (bus.m_axi_bresp != AXI_RESP_OKAY) r_error <= 1'b1;
            r_addr      <= r_addr + (w_burst_beats << BYTE_SHIFT);
            r_remaining <= r_remaining - w_burst_beats;
            if (w_final_burst) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_awvalid <= 1'b1;
              r_state   <= ST_AW;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_stream_axi_writer.sv
// tb/tb_framebuffer_stream_axi_writer.sv - directed self-checking bench for framebuffer_stream_axi_writer
module tb_framebuffer_stream_axi_writer;
  import framebuffer_stream_axi_writer_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int IDW  = 1;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic error;

  always #5 clk = ~clk;

  framebuffer_stream_axi_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();

  framebuffer_stream_axi_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST_BEATS(MAXB), .ID_WIDTH(IDW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_busy  (busy),
    .o_error (error)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] src_data [64];
  logic [3:0]  src_strb [64];
  logic        src_last [64];
  int          src_n   = 0;
  int          src_idx = 0;

  logic [31:0] aw_addr_q  [$];
  logic [7:0]  aw_len_q   [$];
  logic [2:0]  aw_size_q  [$];
  logic [1:0]  aw_burst_q [$];
  logic [31:0] w_data_q   [$];
  logic [3:0]  w_strb_q   [$];
  logic        w_last_q   [$];

  logic [1:0]  b_resp_cfg [8];
  int          b_idx     = 0;
  int          pending_b = 0;
  bit          gaps        = 0;
  bit          hold_wready = 0;

  // Pixel source and memory slave: drive on negedge, record handshakes 1 ns later
  // (these are exactly the handshakes that complete at the next posedge).
  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tstrb  = '0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bid     = '0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bvalid  = 1'b0;
    foreach (b_resp_cfg[i]) b_resp_cfg[i] = 2'b00;
    forever begin
      @(negedge clk);
      if (src_idx < src_n) begin
        bus.s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.s_axis_tdata  = src_data[src_idx];
        bus.s_axis_tstrb  = src_strb[src_idx];
        bus.s_axis_tlast  = src_last[src_idx];
      end else begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
      end
      bus.m_axi_awready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_axi_wready  = hold_wready ? 1'b0 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (pending_b > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = b_resp_cfg[b_idx & 7];
      end else begin
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
      end
      #1;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_addr_q.push_back(bus.m_axi_awaddr);
        aw_len_q.push_back(bus.m_axi_awlen);
        aw_size_q.push_back(bus.m_axi_awsize);
        aw_burst_q.push_back(bus.m_axi_awburst);
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_data_q.push_back(bus.m_axi_wdata);
        w_strb_q.push_back(bus.m_axi_wstrb);
        w_last_q.push_back(bus.m_axi_wlast);
        if (bus.m_axi_wlast) pending_b++;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) src_idx++;
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        pending_b--;
        b_idx++;
      end
    end
  end

  task automatic clear_model();
    src_n = 0;
    src_idx = 0;
    aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete(); aw_burst_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    b_idx = 0;
    pending_b = 0;
    foreach (b_resp_cfg[i]) b_resp_cfg[i] = 2'b00;
    gaps = 0;
    hold_wready = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic load_src(input int n, input logic [31:0] base, input int last_idx);
    for (int i = 0; i < n; i++) begin
      src_data[i] = base + 32'(i) * 32'h0001_0101;
      src_strb[i] = 4'hF ^ 4'(i);
      src_last[i] = (i == last_idx);
    end
    src_idx = 0;
    src_n = n;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] nbytes);
    @(negedge clk);
    bus.s_avalid = 1'b1;
    bus.s_aaddr  = addr;
    bus.s_abytes = nbytes;
    @(negedge clk);
    bus.s_avalid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      #2;
      if (!busy && pending_b == 0 && src_idx >= src_n) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Number of recorded W beats whose data/strobe/wlast differ from the source.
  function automatic int stream_mismatches(input logic [63:0] exp_last);
    int bad = 0;
    for (int i = 0; i < w_data_q.size(); i++) begin
      if (i >= src_n) bad++;
      else if (w_data_q[i] !== src_data[i] || w_strb_q[i] !== src_strb[i] ||
               w_last_q[i] !== exp_last[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.s_avalid = 1'b0;
    bus.s_aaddr  = '0;
    bus.s_abytes = '0;
    repeat (3) @(negedge clk);
    #2;
    n_vec++; if (bus.s_aready !== 1'b1)      begin n_fail++; $display("FAIL reset_aready got %b exp 1", bus.s_aready); end
    n_vec++; if (bus.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", bus.s_axis_tready); end
    n_vec++; if (bus.m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid got %b exp 0", bus.m_axi_awvalid); end
    n_vec++; if (bus.m_axi_wvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_wvalid got %b exp 0", bus.m_axi_wvalid); end
    n_vec++; if (bus.m_axi_bready !== 1'b0)  begin n_fail++; $display("FAIL reset_bready got %b exp 0", bus.m_axi_bready); end
    n_vec++; if (busy !== 1'b0)              begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (error !== 1'b0)             begin n_fail++; $display("FAIL reset_error got %b exp 0", error); end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_single_burst();
    bit ok;
    int bad;
    load_src(16, 32'hC0DE_0000, 15);
    @(negedge clk); #2;
    n_vec++; if (bus.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL stall_before_cmd tready got %b exp 0", bus.s_axis_tready); end
    send_cmd(32'h0000_1000, 32'd64);
    #2;
    n_vec++; if (bus.m_axi_awvalid !== 1'b1) begin n_fail++; $display("FAIL single_awvalid_after_accept got %b exp 1", bus.m_axi_awvalid); end
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    wait_done(400, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout done got %b exp 1", ok); end
    n_vec++; if (aw_addr_q.size() !== 1) begin n_fail++; $display("FAIL single_aw_count got %0d exp 1", aw_addr_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h1000) begin n_fail++; $display("FAIL single_awaddr got %h exp 00001000", aw_addr_q[0]); end
      n_vec++; if (aw_len_q[0] !== 8'd15)     begin n_fail++; $display("FAIL single_awlen got %0d exp 15", aw_len_q[0]); end
      n_vec++; if (aw_size_q[0] !== 3'd2)     begin n_fail++; $display("FAIL single_awsize got %0d exp 2", aw_size_q[0]); end
      n_vec++; if (aw_burst_q[0] !== 2'b01)   begin n_fail++; $display("FAIL single_awburst got %b exp 01", aw_burst_q[0]); end
    end
    n_vec++; if (w_data_q.size() !== 16) begin n_fail++; $display("FAIL single_w_count got %0d exp 16", w_data_q.size()); end
    bad = stream_mismatches(64'h0000_0000_0000_8000);
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL single_stream bad_beats got %0d exp 0", bad); end
    n_vec++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error got %b exp 0", error); end
    n_vec++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL single_busy_end got %b exp 0", busy); end
    clear_model();
  endtask

  task automatic test_multi_burst();
    bit ok;
    int bad;
    load_src(25, 32'h5A00_0000, 24);
    send_cmd(32'h0000_1000, 32'd100);
    wait_done(400, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL multi_timeout done got %b exp 1", ok); end
    n_vec++; if (aw_addr_q.size() !== 2) begin n_fail++; $display("FAIL multi_aw_count got %0d exp 2", aw_addr_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd15) begin n_fail++; $display("FAIL multi_aw0 got %h/%0d exp 00001000/15", aw_addr_q[0], aw_len_q[0]); end
      n_vec++; if (aw_addr_q[1] !== 32'h1040 || aw_len_q[1] !== 8'd8)  begin n_fail++; $display("FAIL multi_aw1 got %h/%0d exp 00001040/8", aw_addr_q[1], aw_len_q[1]); end
    end
    n_vec++; if (w_data_q.size() !== 25) begin n_fail++; $display("FAIL multi_w_count got %0d exp 25", w_data_q.size()); end
    bad = stream_mismatches(64'h0000_0000_0100_8000);
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL multi_stream bad_beats got %0d exp 0", bad); end
    n_vec++; if (error !== 1'b0) begin n_fail++; $display("FAIL multi_error got %b exp 0", error); end
    clear_model();
  endtask

  task automatic test_back_to_back_gaps();
    bit ok;
    int bad;
    load_src(32, 32'h0BAD_F000, 31);
    gaps = 1;
    send_cmd(32'h0000_2000, 32'd128);
    wait_done(2000, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gaps_timeout done got %b exp 1", ok); end
    n_vec++; if (aw_addr_q.size() !== 2) begin n_fail++; $display("FAIL gaps_aw_count got %0d exp 2", aw_addr_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h2000 || aw_len_q[0] !== 8'd15) begin n_fail++; $display("FAIL gaps_aw0 got %h/%0d exp 00002000/15", aw_addr_q[0], aw_len_q[0]); end
      n_vec++; if (aw_addr_q[1] !== 32'h2040 || aw_len_q[1] !== 8'd15) begin n_fail++; $display("FAIL gaps_aw1 got %h/%0d exp 00002040/15", aw_addr_q[1], aw_len_q[1]); end
    end
    n_vec++; if (w_data_q.size() !== 32) begin n_fail++; $display("FAIL gaps_w_count got %0d exp 32", w_data_q.size()); end
    bad = stream_mismatches(64'h0000_0000_8000_8000);
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL gaps_stream bad_beats got %0d exp 0", bad); end
    n_vec++; if (error !== 1'b0) begin n_fail++; $display("FAIL gaps_error got %b exp 0", error); end
    clear_model();
  endtask

  task automatic test_slverr_then_zero_bytes();
    bit ok;
    bit saw_busy;
    bit saw_aw;
    load_src(32, 32'hE000_0000, 31);
    b_resp_cfg[0] = AXI_RESP_SLVERR;
    send_cmd(32'h0000_3000, 32'd128);
    wait_done(400, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL slverr_timeout done got %b exp 1", ok); end
    n_vec++; if (aw_addr_q.size() !== 2) begin n_fail++; $display("FAIL slverr_aw_count got %0d exp 2", aw_addr_q.size()); end
    n_vec++; if (error !== 1'b1) begin n_fail++; $display("FAIL slverr_error got %b exp 1", error); end
    clear_model();
    saw_busy = 0;
    saw_aw = 0;
    send_cmd(32'h0000_4000, 32'd0);
    for (int c = 0; c < 6; c++) begin
      #2;
      if (busy) saw_busy = 1;
      if (bus.m_axi_awvalid) saw_aw = 1;
      @(negedge clk);
    end
    #2;
    n_vec++; if (error !== 1'b0)      begin n_fail++; $display("FAIL zero_clears_error got %b exp 0", error); end
    n_vec++; if (saw_busy !== 1'b0)   begin n_fail++; $display("FAIL zero_busy_seen got %b exp 0", saw_busy); end
    n_vec++; if (saw_aw !== 1'b0)     begin n_fail++; $display("FAIL zero_awvalid_seen got %b exp 0", saw_aw); end
    n_vec++; if (bus.s_aready !== 1'b1) begin n_fail++; $display("FAIL zero_aready got %b exp 1", bus.s_aready); end
    clear_model();
  endtask

  task automatic test_tlast_early();
    bit ok;
    int bad;
    load_src(16, 32'h7700_0000, 9);
    send_cmd(32'h0000_1000, 32'd64);
    wait_done(400, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tlast_timeout done got %b exp 1", ok); end
    n_vec++; if (w_data_q.size() !== 16) begin n_fail++; $display("FAIL tlast_w_count got %0d exp 16", w_data_q.size()); end
    bad = stream_mismatches(64'h0000_0000_0000_8000);
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL tlast_stream bad_beats got %0d exp 0", bad); end
    n_vec++; if (error !== 1'b1) begin n_fail++; $display("FAIL tlast_error got %b exp 1", error); end
    clear_model();
  endtask

  task automatic test_4k_boundary();
    bit ok;
    int bad;
    load_src(8, 32'h4444_0000, 7);
    send_cmd(32'h0000_0FF8, 32'd32);
    wait_done(400, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b4k_timeout done got %b exp 1", ok); end
`ifdef STREAM_AXI_WRITER_4K_SPLIT_EN
    n_vec++; if (aw_addr_q.size() !== 2) begin n_fail++; $display("FAIL b4k_aw_count got %0d exp 2", aw_addr_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd1) begin n_fail++; $display("FAIL b4k_aw0 got %h/%0d exp 00000ff8/1", aw_addr_q[0], aw_len_q[0]); end
      n_vec++; if (aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) begin n_fail++; $display("FAIL b4k_aw1 got %h/%0d exp 00001000/5", aw_addr_q[1], aw_len_q[1]); end
    end
    bad = stream_mismatches(64'h0000_0000_0000_0082);
`else
    n_vec++; if (aw_addr_q.size() !== 1) begin n_fail++; $display("FAIL b4k_aw_count got %0d exp 1", aw_addr_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h0FF8 || aw_len_q[0] !== 8'd7) begin n_fail++; $display("FAIL b4k_aw0 got %h/%0d exp 00000ff8/7", aw_addr_q[0], aw_len_q[0]); end
    end
    bad = stream_mismatches(64'h0000_0000_0000_0080);
`endif
    n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL b4k_stream bad_beats got %0d exp 0", bad); end
    n_vec++; if (error !== 1'b0) begin n_fail++; $display("FAIL b4k_error got %b exp 0", error); end
    clear_model();
  endtask

  task automatic test_reset_mid_w();
    bit ok;
    load_src(32, 32'h1234_0000, 31);
    hold_wready = 1;
    send_cmd(32'h0000_5000, 32'd128);
    repeat (4) @(negedge clk);
    #2;
    n_vec++; if (bus.m_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL midw_in_w wvalid got %b exp 1", bus.m_axi_wvalid); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 || bus.m_axi_bready !== 1'b0)
      begin n_fail++; $display("FAIL midw_valids got aw=%b w=%b b=%b exp 000", bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready); end
    n_vec++; if (bus.s_aready !== 1'b1) begin n_fail++; $display("FAIL midw_aready got %b exp 1", bus.s_aready); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midw_busy got %b exp 0", busy); end
    reset_dut();
    load_src(2, 32'h9900_0000, 1);
    send_cmd(32'h0000_6000, 32'd8);
    wait_done(200, ok);
    n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_timeout done got %b exp 1", ok); end
    n_vec++; if (aw_len_q.size() !== 1 || w_data_q.size() !== 2)
      begin n_fail++; $display("FAIL post_reset_counts got aw=%0d w=%0d exp aw=1 w=2", aw_len_q.size(), w_data_q.size()); end
    else begin
      n_vec++; if (aw_addr_q[0] !== 32'h6000 || aw_len_q[0] !== 8'd1) begin n_fail++; $display("FAIL post_reset_aw got %h/%0d exp 00006000/1", aw_addr_q[0], aw_len_q[0]); end
    end
    clear_model();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_back_to_back_gaps();
    test_slverr_then_zero_bytes();
    test_tlast_early();
    test_4k_boundary();
    test_reset_mid_w();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
